// File: rtl/btn_evt_decoder.sv
// Button event queue: buffers scanner button codes in a small FIFO for a downstream consumer.
// Optional repeat suppression is built only when BTN_EVT_DEDUP_EN is defined.
module btn_evt_decoder #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DEDUP_WINDOW = 1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_CHANGE_FLAG,
    input  logic [1:0] WHICH_BTN_POSEDGE,
    output logic       EVT_VALID,
    output logic [1:0] EVT_CODE,
    output logic [3:0] EVT_ONEHOT,
    input  logic       EVT_READY,
    output logic [3:0] FIFO_LEVEL,
    output logic [7:0] OVERFLOW_CNT
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [1:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]      level_q, level_d;
    logic [7:0]      ovf_q, ovf_d;

    logic not_empty, full, pop, dup, accept, drop;

    assign not_empty = (level_q != 4'd0);
    assign full      = (level_q == 4'(FIFO_DEPTH));
    assign pop       = not_empty && EVT_READY;
    // A pop in the same cycle frees the slot, so a push on a full queue still lands.
    assign accept    = BTN_CHANGE_FLAG && !dup && (!full || pop);
    assign drop      = BTN_CHANGE_FLAG && !dup && full && !pop;

`ifdef BTN_EVT_DEDUP_EN
    logic [1:0]  last_code_q, last_code_d;
    logic        have_last_q, have_last_d;
    logic [15:0] win_cnt_q, win_cnt_d;

    assign dup = have_last_q && (WHICH_BTN_POSEDGE == last_code_q)
                 && (win_cnt_q < 16'(DEDUP_WINDOW));

    always_comb begin
        last_code_d = last_code_q;
        have_last_d = have_last_q;
        win_cnt_d   = win_cnt_q;
        if (win_cnt_q < 16'(DEDUP_WINDOW)) begin
            win_cnt_d = win_cnt_q + 16'd1;
        end
        // Counter holds k exactly k cycles after the accepting edge.
        if (accept) begin
            last_code_d = WHICH_BTN_POSEDGE;
            have_last_d = 1'b1;
            win_cnt_d   = 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_code_q <= 2'd0;
            have_last_q <= 1'b0;
            win_cnt_q   <= 16'd0;
        end else begin
            last_code_q <= last_code_d;
            have_last_q <= have_last_d;
            win_cnt_q   <= win_cnt_d;
        end
    end
`else
    logic unused_dedup_window;
    assign unused_dedup_window = (DEDUP_WINDOW != 0);
    assign dup = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            level_d = level_q + 4'd1;
        end else if (pop && !accept) begin
            level_d = level_q - 4'd1;
        end
        if (drop && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
            ovf_q    <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never reset; the outputs mask it whenever the queue is empty.
    always_ff @(posedge CLK) begin
        if (accept && !RESET) begin
            mem_q[wr_ptr_q] <= WHICH_BTN_POSEDGE;
        end
    end

    always_comb begin
        EVT_VALID  = not_empty;
        EVT_CODE   = 2'd0;
        EVT_ONEHOT = 4'b0000;
        if (not_empty) begin
            EVT_CODE   = mem_q[rd_ptr_q];
            EVT_ONEHOT = 4'b0001 << mem_q[rd_ptr_q];
        end
    end

    assign FIFO_LEVEL   = level_q;
    assign OVERFLOW_CNT = ovf_q;

endmodule

// File: tb/tb_btn_evt_decoder.sv
// Directed self-checking bench for btn_evt_decoder (FIFO_DEPTH=4, DEDUP_WINDOW=10).
module tb_btn_evt_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag;
    logic [1:0] code;
    logic       ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [3:0] evt_onehot;
    logic [3:0] fifo_level;
    logic [7:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    btn_evt_decoder #(
        .FIFO_DEPTH  (4),
        .DEDUP_WINDOW(10)
    ) dut (
        .CLK              (clk),
        .RESET            (reset),
        .BTN_CHANGE_FLAG  (flag),
        .WHICH_BTN_POSEDGE(code),
        .EVT_VALID        (evt_valid),
        .EVT_CODE         (evt_code),
        .EVT_ONEHOT       (evt_onehot),
        .EVT_READY        (ready),
        .FIFO_LEVEL       (fifo_level),
        .OVERFLOW_CNT     (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply current inputs at the next rising edge, then let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c);
        flag = 1'b1;
        code = c;
        step();
        flag = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int exp);
        check(tag, evt_code, exp);
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_code"}, evt_code, 0);
        check({tag, "_onehot"}, evt_onehot, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ovf"}, ovf_cnt, 0);
    endtask

    initial begin
        reset = 1'b1;
        flag  = 1'b0;
        code  = 2'd0;
        ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_all_zero("reset");

        // Single event, held until accepted
        push(2'd2);
        check("single_valid", evt_valid, 1);
        check("single_code", evt_code, 2);
        check("single_onehot", evt_onehot, 4'b0100);
        check("single_level", fifo_level, 1);
        idle(3);
        check("hold_code", evt_code, 2);
        check("hold_onehot", evt_onehot, 4'b0100);
        ready = 1'b1;
        step();
        check("popped_valid", evt_valid, 0);
        check("popped_level", fifo_level, 0);
        step();
        ready = 1'b0;
        check("ready_empty_level", fifo_level, 0);
        check("ready_empty_onehot", evt_onehot, 0);

        // Overflow: two drops, order preserved
        push(2'd0); push(2'd1); push(2'd2); push(2'd3); push(2'd0); push(2'd1);
        check("ovf_level", fifo_level, 4);
        check("ovf_cnt", ovf_cnt, 2);
        check("ovf_onehot", evt_onehot, 4'b0001);
        pop_check("ovf_pop0", 0);
        pop_check("ovf_pop1", 1);
        pop_check("ovf_pop2", 2);
        pop_check("ovf_pop3", 3);
        check("ovf_drained", evt_valid, 0);

        // Full queue with simultaneous push and pop
        idle(12);
        push(2'd3); push(2'd0); push(2'd1); push(2'd2);
        check("full_level", fifo_level, 4);
        flag  = 1'b1;
        code  = 2'd3;
        ready = 1'b1;
        step();
        flag  = 1'b0;
        ready = 1'b0;
        check("fullpp_level", fifo_level, 4);
        check("fullpp_ovf", ovf_cnt, 2);
        pop_check("fullpp_pop0", 0);
        pop_check("fullpp_pop1", 1);
        pop_check("fullpp_pop2", 2);
        pop_check("fullpp_pop3", 3);
        check("fullpp_empty", fifo_level, 0);

        // Push and pop on empty queue: push only
        flag  = 1'b1;
        code  = 2'd2;
        ready = 1'b1;
        step();
        flag  = 1'b0;
        ready = 1'b0;
        check("emptypp_level", fifo_level, 1);
        check("emptypp_code", evt_code, 2);
        pop_check("emptypp_pop", 2);

        // Reset mid-operation, with a competing push and pop
        push(2'd1); push(2'd2); push(2'd3);
        check("midrst_pre_level", fifo_level, 3);
        reset = 1'b1;
        flag  = 1'b1;
        code  = 2'd2;
        ready = 1'b1;
        step();
        reset = 1'b0;
        flag  = 1'b0;
        ready = 1'b0;
        check_all_zero("midrst");
        push(2'd1);
        check("midrst_after_valid", evt_valid, 1);
        check("midrst_after_code", evt_code, 1);
        check("midrst_after_onehot", evt_onehot, 4'b0010);

        // Repeat suppression window: code 1 at cycles 0, 5, 12
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(2'd1);
        idle(4);
        push(2'd1);
        idle(6);
        push(2'd1);
`ifdef BTN_EVT_DEDUP_EN
        check("dedup_level", fifo_level, 2);
`else
        check("dedup_level", fifo_level, 3);
`endif
        check("dedup_ovf", ovf_cnt, 0);

        // Overflow counter saturation
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        for (int i = 0; i < 260; i++) push(2'(i % 2));
        check("sat_ovf", ovf_cnt, 255);
        check("sat_level", fifo_level, 4);
        check("sat_head", evt_code, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
